// File: rtl/serpent_pkg.sv
// Shared Serpent definitions: S-box tables, key-schedule constants, key length
// encoding and the bitsliced S-box helper used by both key schedule and cipher.
package serpent_pkg;

  localparam int unsigned NUM_SUBKEYS = 33;
  localparam int unsigned ROUND_IDX_W = 6;
  localparam logic [31:0] PHI         = 32'h9e3779b9;

  typedef enum logic [1:0] {
    KEY_128 = 2'd0,
    KEY_192 = 2'd1,
    KEY_256 = 2'd2
  } key_len_e;

  localparam logic [3:0] SBOX [0:7][0:15] = '{
    '{4'd3,  4'd8,  4'd15, 4'd1,  4'd10, 4'd6,  4'd5,  4'd11, 4'd14, 4'd13, 4'd4,  4'd2,  4'd7,  4'd0,  4'd9,  4'd12},
    '{4'd15, 4'd12, 4'd2,  4'd7,  4'd9,  4'd0,  4'd5,  4'd10, 4'd1,  4'd11, 4'd14, 4'd8,  4'd6,  4'd13, 4'd3,  4'd4},
    '{4'd8,  4'd6,  4'd7,  4'd9,  4'd3,  4'd12, 4'd10, 4'd15, 4'd13, 4'd1,  4'd14, 4'd4,  4'd0,  4'd11, 4'd5,  4'd2},
    '{4'd0,  4'd15, 4'd11, 4'd8,  4'd12, 4'd9,  4'd6,  4'd3,  4'd13, 4'd1,  4'd2,  4'd4,  4'd10, 4'd7,  4'd5,  4'd14},
    '{4'd1,  4'd15, 4'd8,  4'd3,  4'd12, 4'd0,  4'd11, 4'd6,  4'd2,  4'd5,  4'd4,  4'd10, 4'd9,  4'd14, 4'd7,  4'd13},
    '{4'd15, 4'd5,  4'd2,  4'd11, 4'd4,  4'd10, 4'd9,  4'd12, 4'd0,  4'd3,  4'd14, 4'd8,  4'd13, 4'd6,  4'd7,  4'd1},
    '{4'd7,  4'd2,  4'd12, 4'd5,  4'd8,  4'd4,  4'd6,  4'd11, 4'd14, 4'd9,  4'd1,  4'd15, 4'd13, 4'd3,  4'd10, 4'd0},
    '{4'd1,  4'd13, 4'd15, 4'd0,  4'd14, 4'd8,  4'd2,  4'd11, 4'd7,  4'd4,  4'd12, 4'd10, 4'd9,  4'd3,  4'd5,  4'd6}
  };

  // Bit j of each input word forms one nibble (w0 is bit 0); result is {k3,k2,k1,k0}.
  function automatic logic [127:0] sbox_bitslice(input logic [2:0]  idx,
                                                 input logic [31:0] w0,
                                                 input logic [31:0] w1,
                                                 input logic [31:0] w2,
                                                 input logic [31:0] w3);
    logic [127:0] k;
    logic [3:0]   nib;
    logic [3:0]   sub;
    k = '0;
    for (int unsigned j = 0; j < 32; j++) begin
      nib        = {w3[j], w2[j], w1[j], w0[j]};
      sub        = SBOX[idx][nib];
      k[j]       = sub[0];
      k[32 + j]  = sub[1];
      k[64 + j]  = sub[2];
      k[96 + j]  = sub[3];
    end
    return k;
  endfunction

endpackage

// File: rtl/serpent_key_schedule_if.sv
// Key-load / subkey-read bus between the key schedule and its controller.
interface serpent_key_schedule_if;
  import serpent_pkg::*;

  logic                   i_master_key_valid;
  logic [1:0]             i_key_len;
  logic [255:0]           i_key;
  logic [ROUND_IDX_W-1:0] i_rd_idx;
  logic [127:0]           o_subkey;
  logic                   o_keys_ready;
  logic                   o_busy;

  modport master (
    output i_master_key_valid, i_key_len, i_key, i_rd_idx,
    input  o_subkey, o_keys_ready, o_busy
  );

  modport slave (
    input  i_master_key_valid, i_key_len, i_key, i_rd_idx,
    output o_subkey, o_keys_ready, o_busy
  );
endinterface

// File: rtl/serpent_prekey_step.sv
// Four chained prekey recurrences: consumes the 8-word window w[i-8..i-1]
// (word 0 oldest) and produces w[i..i+3] plus the window shifted by four.
module serpent_prekey_step
  import serpent_pkg::*;
(
  input  logic [255:0] window,
  input  logic [31:0]  base_idx,
  output logic [255:0] next_window,
  output logic [127:0] words
);

  // Extend the window by four words, each rotated left by 11.
  always_comb begin : chain
    logic [31:0] ext [0:11];
    logic [31:0] mix;
    for (int unsigned n = 0; n < 8; n++) begin
      ext[n] = window[32*n +: 32];
    end
    for (int unsigned k = 0; k < 4; k++) begin
      mix        = ext[k] ^ ext[k+3] ^ ext[k+5] ^ ext[k+7] ^ PHI ^ (base_idx + k);
      ext[k + 8] = {mix[20:0], mix[31:21]};
    end
    next_window = '0;
    words       = '0;
    for (int unsigned n = 0; n < 8; n++) begin
      next_window[32*n +: 32] = ext[n + 4];
    end
    for (int unsigned k = 0; k < 4; k++) begin
      words[32*k +: 32] = ext[k + 8];
    end
  end

endmodule

// File: rtl/serpent_key_schedule.sv
// Serpent key expansion: pads the user key, runs the prekey recurrence four
// words per cycle and stores the 33 bitsliced subkeys in a readable bank.
module serpent_key_schedule
  import serpent_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rstn,
  serpent_key_schedule_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_e;

  localparam logic [ROUND_IDX_W-1:0] LAST_IDX = ROUND_IDX_W'(NUM_SUBKEYS - 1);

  state_e                 state, state_next;
  logic [ROUND_IDX_W-1:0] round, round_next;
  logic [255:0]           window, window_step, padded_key;
  logic [127:0]           step_words, subkey_new;
  logic [2:0]             sbox_idx;
  logic                   load, bank_we;
  logic [127:0]           bank [0:NUM_SUBKEYS-1];

  assign load     = bus.i_master_key_valid;
  assign sbox_idx = 3'd3 - round[2:0];

  serpent_prekey_step u_step (
    .window      (window),
    .base_idx    ({24'd0, round, 2'b00}),
    .next_window (window_step),
    .words       (step_words)
  );

  assign subkey_new = sbox_bitslice(sbox_idx, step_words[31:0], step_words[63:32],
                                    step_words[95:64], step_words[127:96]);

  // Short keys: zero above the key length, then a single 1 bit just past it.
  always_comb begin
    padded_key = bus.i_key;
    case (key_len_e'(bus.i_key_len))
      KEY_128: begin
        padded_key[255:128] = '0;
        padded_key[128]     = 1'b1;
      end
      KEY_192: begin
        padded_key[255:192] = '0;
        padded_key[192]     = 1'b1;
      end
      default: ;
    endcase
  end

  // Next state, round counter and bank write enable; a load always restarts.
  always_comb begin
    state_next = state;
    round_next = round;
    bank_we    = 1'b0;
    case (state)
      IDLE, READY: begin
        if (load) begin
          state_next = EXPAND;
          round_next = '0;
        end
      end
      EXPAND: begin
        if (load) begin
          round_next = '0;
        end else begin
          bank_we    = 1'b1;
          round_next = round + 1'b1;
          if (round == LAST_IDX) state_next = READY;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, round counter and prekey window registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state  <= IDLE;
      round  <= '0;
      window <= '0;
    end else begin
      state <= state_next;
      round <= round_next;
      if (load)                 window <= padded_key;
      else if (state == EXPAND) window <= window_step;
    end
  end

  // Subkey bank; deliberately not reset, o_keys_ready qualifies its contents.
  always_ff @(posedge i_clk) begin
    if (bank_we) bank[round] <= subkey_new;
  end

  // Registered read port; same-cycle write to the read index returns old data.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)                    bus.o_subkey <= '0;
    else if (bus.i_rd_idx <= LAST_IDX) bus.o_subkey <= bank[bus.i_rd_idx];
    else                            bus.o_subkey <= '0;
  end

  assign bus.o_busy       = (state == EXPAND);
  assign bus.o_keys_ready = (state == READY);

endmodule

// File: tb/tb_serpent_key_schedule.sv
// Self-checking bench for serpent_key_schedule: a spec-level model computes
// prekeys and subkeys with plain arithmetic and tracks expected bank contents.
module tb_serpent_key_schedule;

  localparam logic [31:0] PHI_M = 32'h9e3779b9;
  localparam logic [255:0] BENCH_KEY =
    256'h00112233445566778899aabbccddeeffffeeddccbbaa99887766554433221100;
  localparam logic [255:0] GARBAGE_KEY =
    {128'hdeadbeefcafef00d123456789abcdef0, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0};

  logic clk  = 1'b0;
  logic rstn = 1'b1;

  serpent_key_schedule_if bus ();

  serpent_key_schedule dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int sbox_tab [8][16] = '{
    '{3,8,15,1,10,6,5,11,14,13,4,2,7,0,9,12},
    '{15,12,2,7,9,0,5,10,1,11,14,8,6,13,3,4},
    '{8,6,7,9,3,12,10,15,13,1,14,4,0,11,5,2},
    '{0,15,11,8,12,9,6,3,13,1,2,4,10,7,5,14},
    '{1,15,8,3,12,0,11,6,2,5,4,10,9,14,7,13},
    '{15,5,2,11,4,10,9,12,0,3,14,8,13,6,7,1},
    '{7,2,12,5,8,4,6,11,14,9,1,15,13,3,10,0},
    '{1,13,15,0,14,8,2,11,7,4,12,10,9,3,5,6}
  };

  logic [31:0]  model_w [0:139];   // model_w[n] holds w[n-8]
  logic [127:0] mbank   [0:32];    // subkeys of the most recently loaded key
  logic [127:0] cur     [0:32];    // expected DUT bank contents
  bit           cur_ok  [0:32];
  int           s         = -1;    // edges since load was sampled, -1 = none
  logic [127:0] exp_sub   = '0;
  bit           sub_known = 1'b1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [255:0] pad_key(input logic [255:0] k, input logic [1:0] len);
    logic [255:0] p;
    p = k;
    if (len == 2'd0) begin
      p[255:128] = '0;
      p[128]     = 1'b1;
    end else if (len == 2'd1) begin
      p[255:192] = '0;
      p[192]     = 1'b1;
    end
    return p;
  endfunction

  function automatic logic [127:0] model_sub(input int sb, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] c,
                                             input logic [31:0] d);
    logic [127:0] k;
    int nib;
    int o;
    k = '0;
    for (int j = 0; j < 32; j++) begin
      nib = 8 * d[j] + 4 * c[j] + 2 * b[j] + a[j];
      o   = sbox_tab[sb][nib];
      for (int bt = 0; bt < 4; bt++) k[32*bt + j] = o[bt];
    end
    return k;
  endfunction

  function automatic void model_expand(input logic [255:0] key, input logic [1:0] len);
    logic [255:0] p;
    logic [31:0]  x;
    p = pad_key(key, len);
    for (int n = 0; n < 8; n++) model_w[n] = p[32*n +: 32];
    for (int i = 0; i < 132; i++) begin
      x = model_w[i] ^ model_w[i+3] ^ model_w[i+5] ^ model_w[i+7] ^ PHI_M ^ i;
      model_w[i+8] = (x << 11) | (x >> 21);
    end
    for (int r = 0; r < 33; r++) begin
      mbank[r] = model_sub(((3 - r) % 8 + 8) % 8, model_w[8+4*r], model_w[9+4*r],
                           model_w[10+4*r], model_w[11+4*r]);
    end
  endfunction

  // Model: expansion progress, expected bank contents and read-port value.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s         <= -1;
      exp_sub   <= '0;
      sub_known <= 1'b1;
    end else begin
      if (bus.i_rd_idx > 6'd32) begin
        exp_sub   <= '0;
        sub_known <= 1'b1;
      end else begin
        exp_sub   <= cur[bus.i_rd_idx];
        sub_known <= cur_ok[bus.i_rd_idx];
      end
      if (bus.i_master_key_valid) s <= 0;
      else if (s >= 0 && s <= 32) begin
        cur[s]    <= mbank[s];
        cur_ok[s] <= 1'b1;
        s         <= s + 1;
      end
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    check("busy", {255'd0, bus.o_busy}, {255'd0, (s >= 0 && s <= 32)});
    check("keys_ready", {255'd0, bus.o_keys_ready}, {255'd0, (s >= 33)});
    if (sub_known) check("subkey", {128'd0, bus.o_subkey}, {128'd0, exp_sub});
  end

  task automatic load_key(input logic [255:0] key, input logic [1:0] len);
    model_expand(key, len);
    bus.i_key              = key;
    bus.i_key_len          = len;
    bus.i_master_key_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_master_key_valid = 1'b0;
  endtask

  // Waits for keys_ready; reads the index being written each cycle.
  task automatic wait_ready(output int busy_cyc, output int ready_at);
    busy_cyc = bus.o_busy ? 1 : 0;
    ready_at = -1;
    for (int c = 1; c <= 60 && ready_at < 0; c++) begin
      bus.i_rd_idx = 6'(c - 1);
      @(posedge clk); #1;
      if (bus.o_busy) busy_cyc++;
      if (bus.o_keys_ready) ready_at = c + 1;
    end
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i <= 34; i++) begin
      bus.i_rd_idx = 6'(i);
      @(posedge clk); #1;
      if (i == 33) check({tag, "_idx33_zero"}, {128'd0, bus.o_subkey}, '0);
    end
    bus.i_rd_idx = 6'd63;
    @(posedge clk); #1;
    check({tag, "_idx63_zero"}, {128'd0, bus.o_subkey}, '0);
    bus.i_rd_idx = 6'd32;
    @(posedge clk); #1;
  endtask

  task automatic full_load(input string tag, input logic [255:0] key, input logic [1:0] len);
    int busy_cyc;
    int ready_at;
    load_key(key, len);
    wait_ready(busy_cyc, ready_at);
    check({tag, "_busy_cycles"}, 256'(busy_cyc), 256'd33);
    check({tag, "_ready_latency"}, 256'(ready_at), 256'd34);
    sweep(tag);
  endtask

  initial begin
    logic [255:0] p;
    int busy_cyc;
    int ready_at;
    rstn                   = 1'b0;
    bus.i_master_key_valid = 1'b0;
    bus.i_key_len          = 2'd2;
    bus.i_key              = '0;
    bus.i_rd_idx           = 6'd63;

    // Hand-computed pins on the model itself.
    model_expand('0, 2'd2);
    check("pin_w0_zero_key", {224'd0, model_w[8]}, {224'd0, 32'hBBCDCCF1});
    check("pin_w1_zero_key", {224'd0, model_w[9]}, {224'd0, 32'hD5AA492F});
    check("pin_bitslice", {128'd0, model_sub(0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0)},
          {128'd0, 32'hFFFFFFFF, 96'h0});
    p = pad_key(GARBAGE_KEY, 2'd0);
    check("pin_pad128_word4", {224'd0, p[159:128]}, {224'd0, 32'h00000001});
    check("pin_pad128_low", {128'd0, p[127:0]}, {128'd0, GARBAGE_KEY[127:0]});
    p = pad_key(GARBAGE_KEY, 2'd1);
    check("pin_pad192_word6", {224'd0, p[223:192]}, {224'd0, 32'h00000001});

    // Reset held two cycles, then 50 idle cycles.
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (50) @(posedge clk);
    #1;

    full_load("zero_key", '0, 2'd2);
    full_load("bench_key", BENCH_KEY, 2'd2);
    full_load("pad128", GARBAGE_KEY, 2'd0);
    full_load("explicit128", {127'd0, 1'b1, GARBAGE_KEY[127:0]}, 2'd2);
    full_load("pad192", GARBAGE_KEY, 2'd1);
    full_load("len3", GARBAGE_KEY, 2'd3);

    // Rekey mid-expansion: B pulses ten cycles after A.
    load_key(GARBAGE_KEY, 2'd2);
    repeat (9) @(posedge clk);
    #1;
    load_key(BENCH_KEY, 2'd2);
    wait_ready(busy_cyc, ready_at);
    check("rekey_busy_cycles", 256'(busy_cyc), 256'd33);
    check("rekey_ready_latency", 256'(ready_at), 256'd34);
    sweep("rekey");

    // Asynchronous reset between edges during expansion.
    load_key(GARBAGE_KEY, 2'd0);
    repeat (14) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    check("async_rst_busy", {255'd0, bus.o_busy}, '0);
    check("async_rst_ready", {255'd0, bus.o_keys_ready}, '0);
    check("async_rst_subkey", {128'd0, bus.o_subkey}, '0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    full_load("after_reset", BENCH_KEY, 2'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/serpent_key_schedule.md
Name: serpent_key_schedule

Overview:
- Upstream stage of serpent_encrypt_top. Expands the 256-bit user key into the 33 bitsliced 128-bit round subkeys K0..K32 and stores them in an internal subkey bank.
- The encrypt datapath reads subkeys by round index.
- Produces one subkey per cycle, so a full expansion completes in 33 cycles after a key load.

Parameters:
- NUM_SUBKEYS, 33: number of round subkeys generated and stored.
- PHI, 32'h9e3779b9: golden-ratio constant in the prekey recurrence.

Ports:
- i_clk  input  1  clock
- i_rstn  input  1  asynchronous active-low reset
- i_master_key_valid  input  1  one-cycle pulse; loads i_key and starts expansion
- i_key_len  input  2  0=128, 1=192, 2=256 bits (3 is treated as 256)
- i_key  input  256  user key; word n = i_key[32n+31:32n]
- i_rd_idx  input  6  subkey index requested by the encrypt core
- o_subkey  output  128  registered subkey, {k3,k2,k1,k0}
- o_keys_ready  output  1  high when all 33 subkeys are valid
- o_busy  output  1  high during expansion

Behaviour:
- Reset (async, i_rstn=0):
  - FSM goes to IDLE.
  - o_subkey=0, o_keys_ready=0, o_busy=0, round counter=0.
  - Bank contents are not cleared; o_keys_ready gates their use.
- Key padding, applied on load:
  - Key of L bits (128/192): word bits above L are zero.
  - Bit L is set to 1.
  - 256-bit key: used unchanged.
- Prekey window: eight 32-bit registers w[-8..-1], loaded from the padded key words 0..7.
- Recurrence: w_i = ROL11(w_{i-8} ^ w_{i-5} ^ w_{i-3} ^ w_{i-1} ^ PHI ^ i).
  - i is a 32-bit index, 0..131.
  - Four chained recurrences per cycle produce w_{4r}..w_{4r+3}.
  - The window shifts by 4 each cycle.
- Subkey r, applied bitsliced with no IP:
  - S-box index = (3 - r) mod 8, i.e. the S-box order 3,2,1,0,7,6,5,4,3,...
  - For bit position j (0..31), the S-box input nibble is {w4r+3[j], w4r+2[j], w4r+1[j], w4r[j]}; bit0 comes from w4r.
  - Output nibble bit b goes to kb[j].
- FSM:
  - IDLE: on i_master_key_valid, load the window, set r=0, go to EXPAND.
  - EXPAND: each cycle write K_r to bank[r] and increment r. After writing r=32, go to READY.
  - READY: hold. A new i_master_key_valid goes to EXPAND.
- Outputs by state:
  - o_busy=1 only in EXPAND.
  - o_keys_ready=1 only in READY. It rises the cycle after K32 is written, which is 34 cycles after the load pulse edge.
- Rekey mid-expansion: i_master_key_valid in EXPAND reloads the window and sets r=0. o_keys_ready stays 0; the old expansion is abandoned.
- Rekey in READY: o_keys_ready drops to 0 on the next edge.
- Read port:
  - o_subkey <= bank[i_rd_idx] each cycle, 1-cycle latency, independent of state.
  - i_rd_idx > 32 gives o_subkey = 0.
  - A read of the index being written in the same cycle returns the old content (read-before-write).
- A simultaneous load pulse and reset: reset wins.

Decomposition:
- serpent_pkg holds:
  - SBOX[0:7][0:15] 4-bit tables;
  - PHI, NUM_SUBKEYS and ROUND_IDX_W=6;
  - the key_len enum (KEY_128, KEY_192, KEY_256);
  - the function sbox_bitslice(idx, w0, w1, w2, w3), shared with the encrypt core.
- Sub-module serpent_prekey_step: combinational 4-word recurrence (window and index in; next window and 4 words out).

Test Plan:
- Reset then idle:
  - Stimulus: hold i_rstn=0 for 2 cycles, release, no load.
  - Required: o_subkey=0, o_keys_ready=0 and o_busy=0 for 50 cycles.
- All-zero 256-bit key:
  - Stimulus: pulse load with key=0, len=2.
  - Required: first prekey w0=32'hBBCDCCF1, o_busy high for exactly 33 cycles, o_keys_ready rises 34 cycles after the pulse.
  - All K0..K32 read back match the golden C model.
- Bench key, 256-bit:
  - Stimulus: key=256'h00112233445566778899aabbccddeeffffeeddccbbaa99887766554433221100.
  - Required: every subkey equals the model. Reading idx 33 and idx 63 returns 0, one cycle after the address is presented.
- 128-bit key padding:
  - Stimulus: len=0, upper 128 key bits set to garbage.
  - Required: the padded window word 4 = 32'h00000001, and subkeys equal those of the explicit zero-padded key with bit 128 set.
- Rekey mid-expansion:
  - Stimulus: load key A, then load key B at cycle 10.
  - Required: o_keys_ready stays 0 until 34 cycles after the B pulse, and all subkeys match key B.
- Async reset during EXPAND:
  - Stimulus: assert i_rstn=0 at cycle 15 between clock edges.
  - Required: o_busy=0 and o_keys_ready=0 immediately. A new load then completes normally.
